ram_bist_master: RTL and testbench

//  Bus initiator for the RAM512x32 read/write/enable/done handshake. On start it takes override
//  of the RAM port, writes a deterministic address-derived pattern to every word, reads each word

---
 rtl/ram_bist_if.sv | 24 ++
 rtl/ram_bist_master.sv | 170 +++++++++++++++++
 tb/tb_ram_bist_master.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// RAM512x32 access bus shared between the BIST initiator (master) and the RAM port (slave).
interface ram_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_done;
    logic                  mem_override;
    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport master (
        input  mem_data_out, mem_done,
        output mem_override, mem_enable, mem_read, mem_write, mem_address, mem_data_in
    );

    modport slave (
        output mem_data_out, mem_done,
        input  mem_override, mem_enable, mem_read, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/ram_bist_master.sv
// RAM BIST initiator: write address-derived pattern, read back and compare, report pass/fail/timeout.
// Optional RAM_BIST_INVERT_EN adds a second write/read pass using the inverted pattern.
module ram_bist_master #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DEPTH      = 512,
    parameter logic [DATA_WIDTH-1:0] SEED       = 32'hA5C3_0000,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    ram_bist_if.master            bus,
    output logic                  o_busy,
    output logic                  o_pass,
    output logic                  o_fail,
    output logic                  o_timeout,
    output logic [ADDR_WIDTH-1:0] o_fail_address,
    output logic [DATA_WIDTH-1:0] o_fail_data
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, PASS, FAIL
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [TW-1:0]         r_tmo, w_tmo_nxt;
    logic                  r_pass, w_pass_nxt;
    logic                  r_fail, w_fail_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic [ADDR_WIDTH-1:0] r_faddr, w_faddr_nxt;
    logic [DATA_WIDTH-1:0] r_fdata, w_fdata_nxt;
    logic                  w_phase, w_phase_nxt;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_pattern;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = SEED ^ DATA_WIDTH'(a);
        return inv ? ~p : p;
    endfunction

`ifdef RAM_BIST_INVERT_EN
    // Phase 0 uses the plain pattern, phase 1 the inverted one.
    logic r_phase;
    always_ff @(posedge i_clk) begin
        if (i_reset) r_phase <= 1'b0;
        else         r_phase <= w_phase_nxt;
    end
    assign w_phase = r_phase;
`else
    assign w_phase = 1'b0;
`endif

    assign w_last    = (r_addr == ADDR_WIDTH'(DEPTH - 1));
    assign w_pattern = pattern(r_addr, w_phase);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_tmo     <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_faddr   <= '0;
            r_fdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_tmo     <= w_tmo_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
            r_timeout <= w_timeout_nxt;
            r_faddr   <= w_faddr_nxt;
            r_fdata   <= w_fdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_tmo_nxt     = '0;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;
        w_faddr_nxt   = r_faddr;
        w_fdata_nxt   = r_fdata;
        w_phase_nxt   = w_phase;
        case (r_state)
            IDLE, PASS, FAIL: begin
                if (i_start) begin
                    w_state_nxt   = WR_REQ;
                    w_addr_nxt    = '0;
                    w_pass_nxt    = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_faddr_nxt   = '0;
                    w_fdata_nxt   = '0;
                    w_phase_nxt   = 1'b0;
                end
            end
            WR_REQ, RD_REQ: begin
                // A done arriving on the expiry cycle still completes the access.
                if (bus.mem_done) begin
                    if (r_state == WR_REQ) begin
                        w_state_nxt = WR_GAP;
                    end else if (bus.mem_data_out != w_pattern) begin
                        w_state_nxt = FAIL;
                        w_fail_nxt  = 1'b1;
                        w_faddr_nxt = r_addr;
                        w_fdata_nxt = bus.mem_data_out;
                    end else begin
                        w_state_nxt = RD_GAP;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_state_nxt   = FAIL;
                    w_fail_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_faddr_nxt   = r_addr;
                    w_fdata_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            WR_GAP: begin
                w_addr_nxt  = w_last ? '0 : r_addr + 1'b1;
                w_state_nxt = w_last ? RD_REQ : WR_REQ;
            end
            RD_GAP: begin
                w_addr_nxt  = w_last ? '0 : r_addr + 1'b1;
                w_state_nxt = RD_REQ;
                if (w_last) begin
`ifdef RAM_BIST_INVERT_EN
                    if (!w_phase) begin
                        w_phase_nxt = 1'b1;
                        w_state_nxt = WR_REQ;
                    end else begin
                        w_state_nxt = PASS;
                        w_pass_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = PASS;
                    w_pass_nxt  = 1'b1;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy           = (r_state == WR_REQ) || (r_state == WR_GAP) ||
                           (r_state == RD_REQ) || (r_state == RD_GAP);
        bus.mem_override = o_busy;
        bus.mem_enable   = (r_state == WR_REQ) || (r_state == RD_REQ);
        bus.mem_read     = (r_state == RD_REQ);
        bus.mem_write    = (r_state == WR_REQ);
        bus.mem_address  = r_addr;
        bus.mem_data_in  = (r_state == WR_REQ) ? w_pattern : '0;
    end

    assign o_pass         = r_pass;
    assign o_fail         = r_fail;
    assign o_timeout      = r_timeout;
    assign o_fail_address = r_faddr;
    assign o_fail_data    = r_fdata;
endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: behavioural RAM with latency, read corruption and write hang knobs.
module tb_ram_bist_master;
    localparam int DW = 32;
    localparam int AW = 9;
`ifdef RAM_BIST_INVERT_EN
    localparam int          NPASS = 2;
    localparam logic [31:0] WORD5 = 32'h5A3C_FFFA;
`else
    localparam int          NPASS = 1;
    localparam logic [31:0] WORD5 = 32'hA5C3_0005;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, pass, fail, tmo;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fdata;

    ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_bist_master dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .bus(bus),
        .o_busy(busy), .o_pass(pass), .o_fail(fail), .o_timeout(tmo),
        .o_fail_address(faddr), .o_fail_data(fdata)
    );

    always #5 clk = ~clk;

    // RAM model
    logic [DW-1:0] mem [512];
    int            lat = 0;
    logic          corrupt_en = 1'b0, hang_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0, hang_addr = '0;
    int            wcnt = 0;
    logic          done;

    assign done = bus.mem_enable && (wcnt >= lat) &&
                  !(hang_en && bus.mem_write && bus.mem_address == hang_addr);
    assign bus.mem_done = done;
    assign bus.mem_data_out = mem[bus.mem_address] ^
                              ((corrupt_en && bus.mem_address == corrupt_addr) ? 32'd1 : 32'd0);

    always @(posedge clk) begin
        if (!bus.mem_enable || done) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
        if (bus.mem_enable && bus.mem_write && done) mem[bus.mem_address] <= bus.mem_data_in;
    end

    // Handshake monitor: stable request until done, gap after every completed access
    int            viol = 0;
    logic          held = 1'b0, prev_acc = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_din;
    logic          h_rd, h_wr;

    always @(posedge clk) begin
        if (prev_acc && bus.mem_enable) viol <= viol + 1;
        if (bus.mem_enable && (bus.mem_read == bus.mem_write)) viol <= viol + 1;
        if (held && bus.mem_enable && (bus.mem_address != h_addr || bus.mem_data_in != h_din ||
                                       bus.mem_read != h_rd || bus.mem_write != h_wr))
            viol <= viol + 1;
        if (held && !bus.mem_enable && !fail) viol <= viol + 1;
        prev_acc <= bus.mem_enable && done && !reset;
        held     <= bus.mem_enable && !done && !reset;
        h_addr   <= bus.mem_address;
        h_din    <= bus.mem_data_in;
        h_rd     <= bus.mem_read;
        h_wr     <= bus.mem_write;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy/override"}, {62'd0, busy, bus.mem_override}, 64'd0);
        check({tag, " enable/rd/wr"}, {61'd0, bus.mem_enable, bus.mem_read, bus.mem_write}, 64'd0);
        check({tag, " address"}, 64'(bus.mem_address), 64'd0);
        check({tag, " data_in"}, 64'(bus.mem_data_in), 64'd0);
        check({tag, " pass/fail/timeout"}, {61'd0, pass, fail, tmo}, 64'd0);
        check({tag, " fail_address"}, 64'(faddr), 64'd0);
        check({tag, " fail_data"}, 64'(fdata), 64'd0);
    endtask

    // Pulse start, then count busy cycles (sampled on falling edges).
    task automatic run_test(input int restart_at, input int stop_at, output int cyc);
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (busy && cyc < stop_at) begin
            cyc++;
            start = (cyc == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        string         name;
        int            lat;
        logic          corrupt_en;
        logic [AW-1:0] corrupt_addr;
        logic          hang_en;
        logic [AW-1:0] hang_addr;
        int            cycles;
        logic          pass, fail, tmo;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fdata;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        vecs[0] = '{"ideal", 0, 1'b0, 9'h000, 1'b0, 9'h000, 2048*NPASS, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0};
        vecs[1] = '{"corrupt", 0, 1'b1, 9'h1F0, 1'b0, 9'h000, 2017, 1'b0, 1'b1, 1'b0, 9'h1F0, 32'hA5C3_01F1};
        vecs[2] = '{"hang", 0, 1'b0, 9'h000, 1'b1, 9'h003, 21, 1'b0, 1'b1, 1'b1, 9'h003, 32'h0};
        vecs[3] = '{"lat4", 3, 1'b0, 9'h000, 1'b0, 9'h000, 5120*NPASS, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            lat          = vecs[i].lat;
            corrupt_en   = vecs[i].corrupt_en;
            corrupt_addr = vecs[i].corrupt_addr;
            hang_en      = vecs[i].hang_en;
            hang_addr    = vecs[i].hang_addr;
            run_test(0, 30000, cyc);
            check({vecs[i].name, " busy cycles"}, 64'(cyc), 64'(vecs[i].cycles));
            check({vecs[i].name, " busy after"}, 64'(busy), 64'd0);
            check({vecs[i].name, " pass"}, 64'(pass), 64'(vecs[i].pass));
            check({vecs[i].name, " fail"}, 64'(fail), 64'(vecs[i].fail));
            check({vecs[i].name, " timeout"}, 64'(tmo), 64'(vecs[i].tmo));
            check({vecs[i].name, " fail_address"}, 64'(faddr), 64'(vecs[i].faddr));
            check({vecs[i].name, " fail_data"}, 64'(fdata), 64'(vecs[i].fdata));
            if (i == 0) check("ideal word5", 64'(mem[5]), 64'(WORD5));
        end
        check("handshake violations", 64'(viol), 64'd0);
        lat = 0; corrupt_en = 1'b0; hang_en = 1'b0;

        // Reset at the 100th busy cycle aborts at once
        run_test(0, 100, cyc);
        check("abort reached cycle 100", 64'(cyc), 64'd100);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        run_test(0, 30000, cyc);
        check("rerun cycles", 64'(cyc), 64'(2048*NPASS));
        check("rerun pass/fail", {62'd0, pass, fail}, 64'd2);
        check("rerun word5", 64'(mem[5]), 64'(WORD5));

        // Start while busy must not restart the test
        run_test(50, 30000, cyc);
        check("restart ignored cycles", 64'(cyc), 64'(2048*NPASS));
        check("restart ignored pass", 64'(pass), 64'd1);
        check("final handshake violations", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
